// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: datapath width, register index width
// and the register bank sweep/run state encoding.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regbank_state_t;

endpackage

// File: rtl/regbank_array.sv
// Raw register storage: one synchronous write port and two asynchronous read
// ports. The array has no reset; the owning block clears it with a sweep.
module regbank_array
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = REG_ADDR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/register_bank.sv
// Integer register file x0-x31 with two registered read ports, write-through
// bypass, hard-wired x0 and a self-clearing sweep after every reset.
module register_bank
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_reg_control,
    input  logic [REG_ADDR_W-1:0] read_register_1,
    input  logic [REG_ADDR_W-1:0] read_register_2,
    input  logic [REG_ADDR_W-1:0] write_reg_to_memory,
    input  logic [XLEN-1:0]       write_data_to_memory,
    output logic [XLEN-1:0]       read_data_1_from_memory_controller,
    output logic [XLEN-1:0]       read_data_2_from_memory_controller,
    output logic                  regbank_ready,
    output logic                  write_dropped
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NREGS - 1);

    regbank_state_t        state;
    logic [REG_ADDR_W-1:0] clear_idx;

    logic                  arr_we;
    logic [REG_ADDR_W-1:0] arr_waddr;
    logic [XLEN-1:0]       arr_wdata;
    logic [XLEN-1:0]       arr_rdata1;
    logic [XLEN-1:0]       arr_rdata2;
    logic [XLEN-1:0]       next_rd1;
    logic [XLEN-1:0]       next_rd2;
    logic                  run_write;

    assign run_write = write_reg_control && (write_reg_to_memory != '0);

    // The sweep owns the write port until it finishes; x0 is never stored.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = '0;
        arr_wdata = '0;
        if (state == CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = clear_idx;
        end else begin
            arr_we    = run_write;
            arr_waddr = write_reg_to_memory;
            arr_wdata = write_data_to_memory;
        end
    end

    regbank_array #(
        .WIDTH (XLEN),
        .DEPTH (NREGS),
        .AW    (REG_ADDR_W)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
        .raddr1 (read_register_1),
        .raddr2 (read_register_2),
        .rdata1 (arr_rdata1),
        .rdata2 (arr_rdata2)
    );

    // A write landing on the same edge wins over stored data, so both ports
    // return identical values when they address the register being written.
    always_comb begin
        next_rd1 = '0;
        next_rd2 = '0;
        if (read_register_1 != '0) begin
            if (write_reg_control && (write_reg_to_memory == read_register_1)) begin
                next_rd1 = write_data_to_memory;
            end else begin
                next_rd1 = arr_rdata1;
            end
        end
        if (read_register_2 != '0) begin
            if (write_reg_control && (write_reg_to_memory == read_register_2)) begin
                next_rd2 = write_data_to_memory;
            end else begin
                next_rd2 = arr_rdata2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                              <= CLEAR;
            clear_idx                          <= '0;
            read_data_1_from_memory_controller <= '0;
            read_data_2_from_memory_controller <= '0;
            regbank_ready                      <= 1'b0;
            write_dropped                      <= 1'b0;
        end else if (state == CLEAR) begin
            read_data_1_from_memory_controller <= '0;
            read_data_2_from_memory_controller <= '0;
            write_dropped                      <= run_write;
            if (clear_idx == LAST_IDX) begin
                state         <= RUN;
                regbank_ready <= 1'b1;
            end else begin
                clear_idx <= clear_idx + 1'b1;
            end
        end else begin
            read_data_1_from_memory_controller <= next_rd1;
            read_data_2_from_memory_controller <= next_rd2;
            write_dropped                      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed checks of register_bank: sweep timing, bypass, x0, dropped writes
// during the sweep, reset mid-run and same-register reads on both ports.
module tb_register_bank;

    logic        clk;
    logic        rst;
    logic        write_reg_control;
    logic [4:0]  read_register_1;
    logic [4:0]  read_register_2;
    logic [4:0]  write_reg_to_memory;
    logic [31:0] write_data_to_memory;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        regbank_ready;
    logic        write_dropped;

    int num_compared   = 0;
    int num_mismatched = 0;
    int edges;

    register_bank #(
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk                                (clk),
        .rst                                (rst),
        .write_reg_control                  (write_reg_control),
        .read_register_1                    (read_register_1),
        .read_register_2                    (read_register_2),
        .write_reg_to_memory                (write_reg_to_memory),
        .write_data_to_memory               (write_data_to_memory),
        .read_data_1_from_memory_controller (rd1),
        .read_data_2_from_memory_controller (rd2),
        .regbank_ready                      (regbank_ready),
        .write_dropped                      (write_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one set of inputs, lets one rising edge pass, returns 1 time unit later.
    task automatic applyStimulus(input logic we, input logic [4:0] widx,
                                 input logic [31:0] wdata,
                                 input logic [4:0] r1, input logic [4:0] r2);
        write_reg_control    = we;
        write_reg_to_memory  = widx;
        write_data_to_memory = wdata;
        read_register_1      = r1;
        read_register_2      = r2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                  = 1'b0;
        write_reg_control    = 1'b0;
        read_register_1      = '0;
        read_register_2      = '0;
        write_reg_to_memory  = '0;
        write_data_to_memory = '0;
        #1;
        checkOutput("reset_ready", {31'b0, regbank_ready}, 32'd0);
        checkOutput("reset_rd1", rd1, 32'd0);
        checkOutput("reset_dropped", {31'b0, write_dropped}, 32'd0);
        #1 rst = 1'b1;

        // Sweep: edges 1..32, with a dropped write to x3 at edge 10.
        for (int e = 1; e <= 32; e++) begin
            if (e == 10) applyStimulus(1'b1, 5'd3, 32'h12345678, 5'd3, 5'd0);
            else         applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            if (e == 1)  checkOutput("ready_edge1", {31'b0, regbank_ready}, 32'd0);
            if (e == 10) begin
                checkOutput("dropped_edge10", {31'b0, write_dropped}, 32'd1);
                checkOutput("clear_rd1_zero", rd1, 32'd0);
            end
            if (e == 11) checkOutput("dropped_edge11", {31'b0, write_dropped}, 32'd0);
            if (e == 31) checkOutput("ready_edge31", {31'b0, regbank_ready}, 32'd0);
            if (e == 32) checkOutput("ready_edge32", {31'b0, regbank_ready}, 32'd1);
        end

        // Edge 33: freshly cleared registers.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        checkOutput("x5_after_sweep", rd1, 32'd0);
        checkOutput("x31_after_sweep", rd2, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        checkOutput("x3_dropped_write", rd1, 32'd0);

        // Bypass on x7, then read back from storage.
        applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0);
        checkOutput("x7_bypass", rd1, 32'hDEADBEEF);
        checkOutput("run_dropped_zero", {31'b0, write_dropped}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
        checkOutput("x8_zero", rd1, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd8, 5'd7);
        checkOutput("x7_storage_p2", rd2, 32'hDEADBEEF);

        // x0 is hard-wired.
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        checkOutput("x0_wr_rd1", rd1, 32'd0);
        checkOutput("x0_wr_rd2", rd2, 32'd0);
        checkOutput("x0_wr_dropped", {31'b0, write_dropped}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("x0_after_rd1", rd1, 32'd0);

        // Both ports on the register being written.
        applyStimulus(1'b1, 5'd9, 32'h00000042, 5'd9, 5'd9);
        checkOutput("x9_bypass_p1", rd1, 32'h00000042);
        checkOutput("x9_bypass_p2", rd2, 32'h00000042);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
        checkOutput("x9_storage_p1", rd1, 32'h00000042);
        checkOutput("x7_storage_p2b", rd2, 32'hDEADBEEF);

        // Write x4, show it, then reset mid-run.
        applyStimulus(1'b1, 5'd4, 32'hA5A5A5A5, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        checkOutput("x4_before_reset", rd1, 32'hA5A5A5A5);
        checkOutput("ready_still_high", {31'b0, regbank_ready}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_rd1", rd1, 32'd0);
        checkOutput("async_rst_rd2", rd2, 32'd0);
        checkOutput("async_rst_ready", {31'b0, regbank_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        edges = 0;
        while (!regbank_ready && edges < 40) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            edges++;
        end
        checkOutput("resweep_edges", 32'(edges), 32'd32);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd9);
        checkOutput("x4_after_resweep", rd1, 32'd0);
        checkOutput("x9_after_resweep", rd2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
